ps2_scancode_receiver: RTL and testbench

- Upstream input stage for the piano game. Receives raw PS/2 keyboard traffic on PS2_CLK/PS2_DAT and deframes 11-bit device-to-host frames.
- Handles the E0 (extended) and F0 (break) prefixes and delivers one decoded key event per keystroke to the game/note logic.
- The note logic maps key events to piano notes and drives the VGA plotter.
- Receive-only: never drives the PS/2 lines.

---
 rtl/ps2_scancode_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
//   Receive-only PS/2 keyboard front end. Conditions the raw PS/2 clock and
//   data lines, deframes 11-bit device-to-host frames (start, 8 data bits
//   LSB first, odd parity, stop) and folds the E0 (extended) and F0 (break)
//   prefixes into a single key event per keystroke.
//
// Ports
//   CLOCK_50    in   system clock
//   reset       in   asynchronous, active-high reset
//   PS2_CLK     in   raw PS/2 clock (asynchronous)
//   PS2_DAT     in   raw PS/2 data (asynchronous)
//   byte_data   out  last correctly received byte (held)
//   byte_valid  out  one-cycle pulse, byte_data updated
//   key_code    out  scancode of the decoded event (held)
//   key_ext     out  event was E0-prefixed (held)
//   key_break   out  event is a release, F0-prefixed (held)
//   key_valid   out  one-cycle pulse, key_* fields updated
//   frame_err   out  one-cycle pulse on parity, stop or timeout error
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_filt_clk;
    logic [FW-1:0]   r_filt_cnt;
    logic            r_fall;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity;
    logic [TW-1:0]   r_timeout;
    logic            r_ext;
    logic            r_brk;
    logic [7:0]      r_byte_data;
    logic            r_byte_valid;
    logic [7:0]      r_key_code;
    logic            r_key_ext;
    logic            r_key_break;
    logic            r_key_valid;
    logic            r_frame_err;

    logic            w_clk_s;
    logic            w_dat_s;
    logic            w_filt_update;
    logic            w_busy;
    logic            w_timeout;
    logic            w_frame_done;
    logic            w_frame_good;

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // The filtered clock only moves once the synchronized clock has disagreed
    // with it for FILTER_LEN samples in a row; shorter glitches are dropped.
    assign w_filt_update = (w_clk_s != r_filt_clk) &&
                           (r_filt_cnt == FW'(FILTER_LEN - 1));

    // Idle lines read as 1, so the synchronizers and filter reset high to
    // avoid a false falling edge coming out of reset.
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of the others.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], PS2_CLK};
            r_dat_sync <= {r_dat_sync[0], PS2_DAT};
            r_fall     <= w_filt_update && !w_clk_s;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (w_filt_update) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        w_next       = r_state;
        w_timeout    = 1'b0;
        w_frame_done = 1'b0;
        w_busy       = (r_state != S_IDLE);
        if (w_busy && (r_timeout == TW'(TIMEOUT_CYCLES))) begin
            // A stalled frame is abandoned even if an edge arrives now.
            w_timeout = 1'b1;
            w_next    = S_IDLE;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat_s) w_next = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP: begin
                    w_next       = S_IDLE;
                    w_frame_done = 1'b1;
                end
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign w_frame_good = w_frame_done && w_dat_s && (^{r_shift, r_parity});

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_parity     <= 1'b0;
            r_timeout    <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_key_code   <= '0;
            r_key_ext    <= 1'b0;
            r_key_break  <= 1'b0;
            r_key_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_key_valid  <= 1'b0;
            r_frame_err  <= 1'b0;

            if (!w_busy || r_fall || w_timeout) begin
                r_timeout <= '0;
            end else begin
                r_timeout <= r_timeout + TW'(1);
            end

            if (r_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        // LSB arrives first, so shift in from the top.
                        r_shift   <= {w_dat_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_dat_s;
                    default:  ;
                endcase
            end

            if (w_timeout || (w_frame_done && !w_frame_good)) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else if (w_frame_good) begin
                r_byte_data  <= r_shift;
                r_byte_valid <= 1'b1;
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_key_code  <= r_shift;
                    r_key_ext   <= r_ext;
                    r_key_break <= r_brk;
                    r_key_valid <= 1'b1;
                    r_ext       <= 1'b0;
                    r_brk       <= 1'b0;
                end
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign key_code   = r_key_code;
    assign key_ext    = r_key_ext;
    assign key_break  = r_key_break;
    assign key_valid  = r_key_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver
//   Drives PS/2 frames into ps2_scancode_receiver and checks every output
//   cycle against a frame-level model: each complete frame yields exactly one
//   expected output event (byte, byte+key, or error), queued in order.
//   The PS/2 clock is much faster than a real keyboard and the timeout is
//   shortened so the whole run stays short.
module tb_ps2_scancode_receiver;

    localparam int HALF       = 50;
    localparam int FLT        = 8;
    localparam int TIMEOUT    = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       frame_err;

    ps2_scancode_receiver #(
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         has_byte;
        bit         has_key;
        bit         has_err;
        logic [7:0] b;
        bit         ext;
        bit         brk;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_ext, m_brk;
    logic [7:0] cur_byte, cur_code;
    bit         cur_ext, cur_brk;
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_bv = 0, n_kv = 0, n_fe = 0;
    int         bv0, kv0, fe0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame-level model: what a keyboard-facing decoder must report.
    task automatic model_frame(input logic [7:0] b, input bit good);
        ev_t e;
        e = '{default: 0};
        if (!good) begin
            e.has_err = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            e.has_byte = 1'b1;
            e.b        = b;
            if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                e.has_key = 1'b1;
                e.ext     = m_ext;
                e.brk     = m_brk;
                m_ext     = 1'b0;
                m_brk     = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        cur_byte = 8'h00;
        cur_code = 8'h00;
        cur_ext  = 1'b0;
        cur_brk  = 1'b0;
    endtask

    // Sends the first nbits of a frame (11 = complete). Data changes in the
    // middle of the high phase; the model is told at the stop-bit fall.
    task automatic send_frame(input logic [7:0] b, input bit par_err,
                              input bit stop_err, input int nbits);
        logic [10:0] fr;
        bit          par;
        par = (($countones(b) % 2) == 0) ^ par_err;
        fr  = {~stop_err, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            wait_cyc(HALF / 2);
            ps2_dat = fr[i];
            wait_cyc(HALF / 2);
            ps2_clk = 1'b0;
            if (i == 10) model_frame(b, !par_err && !stop_err);
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF / 2);
        ps2_dat = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cyc(1);
        wait_cyc(5);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    task automatic snap();
        bv0 = n_bv;
        kv0 = n_kv;
        fe0 = n_fe;
    endtask

    task automatic check_counts(input string name, input int bv, input int kv, input int fe);
        check({name, "_byte_pulses"}, n_bv - bv0, bv);
        check({name, "_key_pulses"},  n_kv - kv0, kv);
        check({name, "_err_pulses"},  n_fe - fe0, fe);
    endtask

    // Compare process: every output cycle is checked against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid || key_valid || frame_err) begin
                n_bv += int'(byte_valid);
                n_kv += int'(key_valid);
                n_fe += int'(frame_err);
                if (exp_q.size() == 0) begin
                    check("pulse_with_no_event", {byte_valid, key_valid, frame_err}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulses", {byte_valid, key_valid, frame_err},
                          {e.has_byte, e.has_key, e.has_err});
                    if (e.has_byte) cur_byte = e.b;
                    if (e.has_key) begin
                        cur_code = e.b;
                        cur_ext  = e.ext;
                        cur_brk  = e.brk;
                    end
                end
            end
            check("held_outputs", {byte_data, key_code, key_ext, key_break},
                  {cur_byte, cur_code, cur_ext, cur_brk});
        end
    end

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within 120000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        model_reset();
        wait_cyc(5);
        check("reset_outputs",
              {byte_data, byte_valid, key_code, key_ext, key_break, key_valid, frame_err}, 0);
        rst = 1'b0;
        wait_cyc(20);

        // Make code 0x1C.
        snap();
        send_frame(8'h1C, 0, 0, 11);
        drain("make");
        check_counts("make", 1, 1, 0);
        check("make_byte_data", byte_data, 8'h1C);
        check("make_key", {key_code, key_ext, key_break}, {8'h1C, 1'b0, 1'b0});

        // Break: F0 1C.
        snap();
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1C, 0, 0, 11);
        drain("break");
        check_counts("break", 2, 1, 0);
        check("break_key", {key_code, key_ext, key_break}, {8'h1C, 1'b0, 1'b1});

        // Extended release: E0 F0 75, then plain 75.
        snap();
        send_frame(8'hE0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h75, 0, 0, 11);
        drain("ext_release");
        check_counts("ext_release", 3, 1, 0);
        check("ext_release_key", {key_code, key_ext, key_break}, {8'h75, 1'b1, 1'b1});
        send_frame(8'h75, 0, 0, 11);
        drain("plain_75");
        check("plain_75_key", {key_code, key_ext, key_break}, {8'h75, 1'b0, 1'b0});

        // Parity error on 0x1C.
        snap();
        send_frame(8'h1C, 1, 0, 11);
        drain("parity");
        check_counts("parity", 0, 0, 1);
        check("parity_byte_held", byte_data, 8'h75);

        // Error after F0 clears the break flag.
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h1C, 1, 0, 11);
        send_frame(8'h1C, 0, 0, 11);
        drain("err_after_f0");
        check("err_after_f0_key", {key_code, key_ext, key_break}, {8'h1C, 1'b0, 1'b0});

        // Timeout after 5 data bits, preceded by E0 to check the flag clears.
        send_frame(8'hE0, 0, 0, 11);
        drain("pre_timeout");
        snap();
        send_frame(8'h55, 0, 0, 6);
        model_frame(8'h55, 0);
        wait_cyc(TIMEOUT + 200);
        drain("timeout");
        check_counts("timeout", 0, 0, 1);
        send_frame(8'h2A, 0, 0, 11);
        drain("after_timeout");
        check("after_timeout_key", {key_code, key_ext, key_break}, {8'h2A, 1'b0, 1'b0});

        // Short low glitch on PS2_CLK while idle.
        snap();
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(40);
        check_counts("glitch", 0, 0, 0);

        // Reset after 4 data bits, with a pending F0.
        send_frame(8'hF0, 0, 0, 11);
        drain("pre_reset");
        send_frame(8'hA5, 0, 0, 5);
        rst = 1'b1;
        model_reset();
        #1;
        check("midframe_reset_outputs",
              {byte_data, byte_valid, key_code, key_ext, key_break, key_valid, frame_err}, 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(20);
        snap();
        send_frame(8'h16, 0, 0, 11);
        drain("after_reset");
        check_counts("after_reset", 1, 1, 0);
        check("after_reset_key", {key_code, key_ext, key_break}, {8'h16, 1'b0, 1'b0});

        // Randomized frames: prefixes, plain codes, parity and stop errors.
        for (int i = 0; i < 20; i++) begin
            int          sel;
            logic [7:0]  b;
            bit          pe, se;
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      b = 8'hE0;
            else if (sel < 4) b = 8'hF0;
            else              b = 8'($urandom_range(0, 255));
            pe = ($urandom_range(0, 7) == 0);
            se = ($urandom_range(0, 11) == 0);
            send_frame(b, pe, se, 11);
            wait_cyc(int'($urandom_range(30, 200)));
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
